phase_clk_sched: RTL and testbench

PHASE_CLK_SCHED -- requirements
Module: phase_clk_sched

---
 rtl/phase_clk_sched.sv | 176 +++++++++++++++++
 tb/tb_phase_clk_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_clk_sched.sv
// Three-phase programmable clock scheduler: one shared phase counter drives three
// offset clocks plus a sample strobe, with a req/ack handshake for reconfiguration.
module phase_clk_sched #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             io_asyncResetn,
    input  logic             i_en,
    input  logic             cfg_req,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_off2,
    input  logic [CNT_W-1:0] cfg_off3,
    output logic             o_clk1,
    output logic             o_clk2,
    output logic             o_clk3,
    output logic             o_sample_stb,
    output logic             o_run,
    output logic             cfg_ack,
    output logic             cfg_err
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_STOP_PEND = 2'd2;

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(9);
    localparam logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(5);
    localparam logic [CNT_W-1:0] DEF_OFF2   = CNT_W'(6);
    localparam logic [CNT_W-1:0] DEF_OFF3   = CNT_W'(3);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_off2;
    logic [CNT_W-1:0] r_off3;

    logic             r_pending;
    logic             r_pend_ok;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_pend_high;
    logic [CNT_W-1:0] r_pend_off2;
    logic [CNT_W-1:0] r_pend_off3;

    logic [2:0]       r_clk;
    logic             r_sample_stb;

    logic             w_active;
    logic             w_last;
    logic             w_apply_slot;
    logic             w_apply;
    logic             w_ack;
    logic             w_req_valid;
    logic [CNT_W:0]   w_p;
    logic [CNT_W:0]   w_cnt_x;
    logic [CNT_W:0]   w_offs [3];
    logic [2:0]       w_phase_hi;

    assign w_active = (r_state != ST_IDLE);
    assign w_last   = (r_cnt == r_period);

    // A pending config lands on the wrap edge while running, or straight away when idle.
    assign w_apply_slot = !w_active || w_last;
    assign w_apply      = r_pending && r_pend_ok && w_apply_slot;
    assign w_ack        = r_pending && (!r_pend_ok || w_apply_slot);

    assign w_req_valid = (cfg_period != '0)
                      && (cfg_high != '0)
                      && (cfg_high <= cfg_period)
                      && (cfg_off2 <= cfg_period)
                      && (cfg_off3 <= cfg_period);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_en) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!i_en) w_state_next = ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
                if (i_en)        w_state_next = ST_RUN;
                else if (w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_cnt_next = (!w_active || w_last) ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge CLK or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_period <= DEF_PERIOD;
            r_high   <= DEF_HIGH;
            r_off2   <= DEF_OFF2;
            r_off3   <= DEF_OFF3;
        end else if (w_apply) begin
            r_period <= r_pend_period;
            r_high   <= r_pend_high;
            r_off2   <= r_pend_off2;
            r_off3   <= r_pend_off3;
        end
    end

    // Validity is judged once at capture so the ack decision only depends on registers.
    always_ff @(posedge CLK or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_pending     <= 1'b0;
            r_pend_ok     <= 1'b0;
            r_pend_period <= '0;
            r_pend_high   <= '0;
            r_pend_off2   <= '0;
            r_pend_off3   <= '0;
        end else if (w_ack) begin
            r_pending <= 1'b0;
        end else if (!r_pending && cfg_req) begin
            r_pending     <= 1'b1;
            r_pend_ok     <= w_req_valid;
            r_pend_period <= cfg_period;
            r_pend_high   <= cfg_high;
            r_pend_off2   <= cfg_off2;
            r_pend_off3   <= cfg_off3;
        end
    end

    assign w_p       = {1'b0, r_period} + (CNT_W+1)'(1);
    assign w_cnt_x   = {1'b0, r_cnt};
    assign w_offs[0] = '0;
    assign w_offs[1] = {1'b0, r_off2};
    assign w_offs[2] = {1'b0, r_off3};

    // Distance past each phase's offset, taken modulo the period without a divider.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            logic [CNT_W:0] w_d;
            assign w_d = (w_cnt_x >= w_offs[gi]) ? (w_cnt_x - w_offs[gi])
                                                 : (w_cnt_x + w_p - w_offs[gi]);
            assign w_phase_hi[gi] = w_active && (w_d < {1'b0, r_high});
        end
    endgenerate

    always_ff @(posedge CLK or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_clk        <= '0;
            r_sample_stb <= 1'b0;
        end else begin
            r_clk        <= w_phase_hi;
            r_sample_stb <= w_active && (r_cnt == '0);
        end
    end

    assign o_clk1       = r_clk[0];
    assign o_clk2       = r_clk[1];
    assign o_clk3       = r_clk[2];
    assign o_sample_stb = r_sample_stb;
    assign o_run        = w_active;
    assign cfg_ack      = w_ack;
    assign cfg_err      = r_pending && !r_pend_ok;

endmodule

// File: tb/tb_phase_clk_sched.sv
// Bench for phase_clk_sched: directed scenarios plus randomized traffic, all checked
// against a cycle-level model built from modular period arithmetic.
module tb_phase_clk_sched;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         io_asyncResetn = 1'b1;
    logic         i_en = 1'b0;
    logic         cfg_req = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_high = '0;
    logic [W-1:0] cfg_off2 = '0;
    logic [W-1:0] cfg_off3 = '0;
    logic         o_clk1, o_clk2, o_clk3, o_sample_stb, o_run, cfg_ack, cfg_err;

    int total = 0;
    int bad = 0;

    phase_clk_sched #(.CNT_W(W)) dut (
        .CLK(CLK), .io_asyncResetn(io_asyncResetn), .i_en(i_en), .cfg_req(cfg_req),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_off2(cfg_off2), .cfg_off3(cfg_off3),
        .o_clk1(o_clk1), .o_clk2(o_clk2), .o_clk3(o_clk3), .o_sample_stb(o_sample_stb),
        .o_run(o_run), .cfg_ack(cfg_ack), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    // Model: running/stopping flags, position in period, active and pending config.
    bit       m_active, m_stop, m_pend, m_pok, m_stb;
    bit [2:0] m_clk;
    int       m_cnt, m_P, m_H;
    int       m_off [3];
    int       pp, ph, po2, po3;

    task automatic model_reset();
        m_active = 0; m_stop = 0; m_pend = 0; m_pok = 0; m_stb = 0; m_clk = '0;
        m_cnt = 0; m_P = 10; m_H = 5;
        m_off[0] = 0; m_off[1] = 6; m_off[2] = 3;
    endtask

    function automatic logic [6:0] exp_vec();
        bit slot;
        slot = !m_active || (m_cnt == m_P - 1);
        return {m_clk[0], m_clk[1], m_clk[2], m_stb, m_active,
                m_pend && (!m_pok || slot), m_pend && !m_pok};
    endfunction

    function automatic logic [6:0] obs();
        return {o_clk1, o_clk2, o_clk3, o_sample_stb, o_run, cfg_ack, cfg_err};
    endfunction

    task automatic model_step();
        bit wrap, slot;
        int rp;
        wrap = m_active && (m_cnt == m_P - 1);
        slot = !m_active || wrap;
        for (int k = 0; k < 3; k++)
            m_clk[k] = m_active && ((((m_cnt - m_off[k]) % m_P) + m_P) % m_P < m_H);
        m_stb = m_active && (m_cnt == 0);
        if (m_pend) begin
            if (m_pok && slot) begin
                m_P = pp; m_H = ph; m_off[1] = po2; m_off[2] = po3;
            end
            if (!m_pok || slot) m_pend = 0;
        end else if (cfg_req) begin
            rp = int'(cfg_period);
            pp = rp + 1; ph = int'(cfg_high); po2 = int'(cfg_off2); po3 = int'(cfg_off3);
            m_pok = (rp >= 1) && (ph >= 1) && (ph <= rp) && (po2 <= rp) && (po3 <= rp);
            m_pend = 1;
        end
        if (!m_active) begin
            if (i_en) begin m_active = 1; m_stop = 0; end
            m_cnt = 0;
        end else begin
            m_cnt = wrap ? 0 : m_cnt + 1;
            if (m_stop && !i_en && wrap) m_active = 0;
            else m_stop = !i_en;
        end
    endtask

    // One clock: model advances on the edge, requester drops cfg_req once acked.
    task automatic tick();
        @(posedge CLK);
        if (io_asyncResetn) model_step();
        @(negedge CLK);
        if (cfg_req && cfg_ack) cfg_req = 1'b0;
    endtask

    task automatic wait_cnt(input int x, output bit ok);
        for (int i = 0; i < 64 && !(m_active && m_cnt == x); i++) tick();
        ok = m_active && (m_cnt == x);
    endtask

    task automatic set_cfg(input int p, input int h, input int o2, input int o3);
        cfg_period = W'(p); cfg_high = W'(h); cfg_off2 = W'(o2); cfg_off3 = W'(o3);
        cfg_req = 1'b1;
    endtask

    task automatic test_reset();
        #2 io_asyncResetn = 1'b0;
        #1;
        total++;
        if (obs() !== 7'b0) begin bad++; $display("FAIL reset_now: got %b want 0000000", obs()); end
        model_reset();
        repeat (3) @(negedge CLK);
        total++;
        if (obs() !== 7'b0) begin bad++; $display("FAIL reset_hold: got %b want 0000000", obs()); end
        io_asyncResetn = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL reset_idle: got %b want %b", obs(), exp_vec()); end
        end
    endtask

    task automatic test_defaults();
        int c, e;
        logic [3:0] w4;
        i_en = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            c = j - 1; e = c % 10;
            w4 = {(e >= 1 && e <= 5), (c >= 1) && (e >= 7 || e <= 1), (e >= 4 && e <= 8), (e == 1)};
            total++;
            if ({o_clk1, o_clk2, o_clk3, o_sample_stb} !== w4) begin
                bad++; $display("FAIL defaults_wave c=%0d: got %b want %b", c, {o_clk1, o_clk2, o_clk3, o_sample_stb}, w4);
            end
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL defaults_model c=%0d: got %b want %b", c, obs(), exp_vec()); end
        end
    endtask

    task automatic test_stop();
        bit ok;
        wait_cnt(2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stop_reach: got cnt %0d want 2", m_cnt); end
        i_en = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            if (j <= 8) begin
                total++;
                if (o_run !== (j <= 7)) begin bad++; $display("FAIL stop_run j=%0d: got %b want %b", j, o_run, (j <= 7)); end
            end
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL stop_model j=%0d: got %b want %b", j, obs(), exp_vec()); end
        end
        i_en = 1'b1;
        tick();
        wait_cnt(2, ok);
        i_en = 1'b0;
        wait_cnt(5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL resume_reach: got cnt %0d want 5", m_cnt); end
        i_en = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick();
            total++;
            if (o_run !== 1'b1 || obs() !== exp_vec()) begin
                bad++; $display("FAIL resume j=%0d: got %b want %b", j, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_invalid();
        int t_h [2]  = '{0, 3};
        int t_o2 [2] = '{2, 7};
        int n1;
        for (int t = 0; t < 2; t++) begin
            set_cfg(5, t_h[t], t_o2[t], 1);
            tick();
            total++;
            if ({cfg_ack, cfg_err} !== 2'b11) begin bad++; $display("FAIL invalid_ack t=%0d: got %b want 11", t, {cfg_ack, cfg_err}); end
            n1 = 0;
            for (int j = 0; j < 10; j++) begin
                tick();
                n1 += int'(o_clk1);
                total++;
                if (obs() !== exp_vec()) begin bad++; $display("FAIL invalid_model t=%0d: got %b want %b", t, obs(), exp_vec()); end
            end
            total++;
            if (n1 != 5) begin bad++; $display("FAIL invalid_keep t=%0d: got %0d highs want 5", t, n1); end
        end
    endtask

    task automatic test_cfg_valid();
        bit seen;
        int at, n1, n2, n3, ns;
        seen = 0; at = -1;
        set_cfg(5, 3, 2, 4);
        for (int j = 0; j < 24 && !seen; j++) begin
            if (cfg_ack === 1'b1) begin seen = 1; at = m_cnt; end
            else begin
                tick();
                total++;
                if (obs() !== exp_vec()) begin bad++; $display("FAIL cfg_wait: got %b want %b", obs(), exp_vec()); end
            end
        end
        total++;
        if (!seen || at != 9 || cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_ack_wrap: got cnt %0d err %b want cnt 9 err 0", at, cfg_err); end
        tick();
        n1 = 0; n2 = 0; n3 = 0; ns = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            n1 += int'(o_clk1); n2 += int'(o_clk2); n3 += int'(o_clk3); ns += int'(o_sample_stb);
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL cfg_model j=%0d: got %b want %b", j, obs(), exp_vec()); end
        end
        total++;
        if (n1 != 6 || n2 != 6 || n3 != 6 || ns != 2) begin
            bad++; $display("FAIL cfg_duty: got %0d/%0d/%0d stb %0d want 6/6/6 stb 2", n1, n2, n3, ns);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_cnt(0, ok);
        set_cfg(7, 2, 1, 1);
        wait_cnt(4, ok);
        total++;
        if (!ok || !m_pend) begin bad++; $display("FAIL rmid_setup: got cnt %0d pend %b want cnt 4 pend 1", m_cnt, m_pend); end
        io_asyncResetn = 1'b0;
        #1;
        total++;
        if (obs() !== 7'b0) begin bad++; $display("FAIL rmid_now: got %b want 0000000", obs()); end
        model_reset();
        cfg_req = 1'b0;
        repeat (2) begin
            tick();
            total++;
            if (obs() !== 7'b0) begin bad++; $display("FAIL rmid_hold: got %b want 0000000", obs()); end
        end
        io_asyncResetn = 1'b1;
        for (int j = 0; j < 25; j++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL rmid_after j=%0d: got %b want %b", j, obs(), exp_vec()); end
        end
    endtask

    task automatic test_min_period();
        logic last;
        int ns;
        i_en = 1'b0;
        for (int j = 0; j < 40 && m_active; j++) tick();
        total++;
        if (o_run !== 1'b0) begin bad++; $display("FAIL min_idle: got run %b want 0", o_run); end
        set_cfg(1, 1, 0, 0);
        tick();
        total++;
        if ({cfg_ack, cfg_err} !== 2'b10) begin bad++; $display("FAIL min_ack: got %b want 10", {cfg_ack, cfg_err}); end
        i_en = 1'b1;
        tick(); tick();
        last = o_clk1; ns = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            total++;
            if (o_clk1 === last) begin bad++; $display("FAIL min_toggle j=%0d: got %b want %b", j, o_clk1, ~last); end
            last = o_clk1;
            ns += int'(o_sample_stb);
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL min_model j=%0d: got %b want %b", j, obs(), exp_vec()); end
        end
        total++;
        if (ns != 5) begin bad++; $display("FAIL min_stb: got %0d want 5", ns); end
    endtask

    task automatic test_random();
        int p;
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 19) == 0) i_en = ~i_en;
            if (!cfg_req && $urandom_range(0, 11) == 0) begin
                p = int'($urandom_range(0, 15));
                set_cfg(p, int'($urandom_range(0, (p < 15) ? p + 1 : 15)),
                        int'($urandom_range(0, (p < 15) ? p + 1 : 15)), int'($urandom_range(0, p)));
            end
            tick();
            total++;
            if (obs() !== exp_vec()) begin bad++; $display("FAIL random j=%0d: got %b want %b", j, obs(), exp_vec()); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_stop();
        test_invalid();
        test_cfg_valid();
        test_reset_mid();
        test_min_period();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
